// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : ALU function codes, RV32I opcodes and operand-select enums.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] FUNC_ZERO = 4'd0;
    localparam logic [3:0] FUNC_ADD  = 4'd1;
    localparam logic [3:0] FUNC_SUB  = 4'd2;
    localparam logic [3:0] FUNC_SLL  = 4'd3;
    localparam logic [3:0] FUNC_SLT  = 4'd4;
    localparam logic [3:0] FUNC_XOR  = 4'd5;
    localparam logic [3:0] FUNC_OR   = 4'd6;
    localparam logic [3:0] FUNC_AND  = 4'd7;
    localparam logic [3:0] FUNC_SRL  = 4'd8;
    localparam logic [3:0] FUNC_SRA  = 4'd9;
    localparam logic [3:0] FUNC_SLTU = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
    typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

    // alt selects SUB/SRA; callers clear it where the encoding has no alternate form.
    function automatic logic [3:0] arith_func(input logic [2:0] f3, input logic alt);
        logic [3:0] f;
        f = FUNC_ZERO;
        case (f3)
            3'b000:  f = alt ? FUNC_SUB : FUNC_ADD;
            3'b001:  f = FUNC_SLL;
            3'b010:  f = FUNC_SLT;
            3'b011:  f = FUNC_SLTU;
            3'b100:  f = FUNC_XOR;
            3'b101:  f = alt ? FUNC_SRA : FUNC_SRL;
            3'b110:  f = FUNC_OR;
            default: f = FUNC_AND;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decoder_if
// Purpose  : Request/response bundle of the ALU operand decoder stage.
//            Optional macro: ALU_DEC_ILLEGAL_EN adds the illegal flag.
// Revision : 1.0
// ============================================================================
interface alu_op_decoder_if #(
    parameter int DataWidth = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic [DataWidth-1:0] pc;
    logic [DataWidth-1:0] rs1_data;
    logic [DataWidth-1:0] rs2_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           alu_func;
    logic [DataWidth-1:0] alu_op1;
    logic [DataWidth-1:0] alu_op2;
    logic [4:0]           rd;
    logic                 rd_we;
`ifdef ALU_DEC_ILLEGAL_EN
    logic                 illegal;
`endif

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_func, alu_op1, alu_op2, rd, rd_we
`ifdef ALU_DEC_ILLEGAL_EN
        , output illegal
`endif
    );

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_func, alu_op1, alu_op2, rd, rd_we
`ifdef ALU_DEC_ILLEGAL_EN
        , input illegal
`endif
    );
endinterface
`default_nettype wire

// File: rtl/alu_dec_comb.sv
`default_nettype none
// ============================================================================
// Module   : alu_dec_comb
// Purpose  : Combinational RV32I decode to ALU function, operand selects and
//            immediate. Optional macro: ALU_DEC_ILLEGAL_EN.
// Revision : 1.0
// ============================================================================
module alu_dec_comb
    import alu_pkg::*;
(
    input  wire logic [31:0] instr_i,
    output logic [3:0]       func_o,
    output op1_sel_e         op1_sel_o,
    output op2_sel_e         op2_sel_o,
    output logic [31:0]      imm_o,
    output logic             rd_we_o
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    output logic             illegal_o
`endif
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;
    logic        w_is_shift;

    assign w_opcode   = instr_i[6:0];
    assign w_f3       = instr_i[14:12];
    assign w_imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_u    = {instr_i[31:12], 12'b0};
    assign w_shamt    = {27'b0, instr_i[24:20]};
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

`ifdef ALU_DEC_ILLEGAL_EN
    logic w_known;
    logic w_bad_f7;
    assign w_known = (w_opcode == OPC_OP)    || (w_opcode == OPC_OP_IMM) ||
                     (w_opcode == OPC_LUI)   || (w_opcode == OPC_AUIPC)  ||
                     (w_opcode == OPC_LOAD)  || (w_opcode == OPC_STORE)  ||
                     (w_opcode == OPC_JAL)   || (w_opcode == OPC_JALR)   ||
                     (w_opcode == OPC_BRANCH);
    // funct7 may be 0100000 only where an alternate (SUB/SRA/SRAI) exists.
    always_comb begin
        w_bad_f7 = 1'b0;
        if (w_opcode == OPC_OP)
            w_bad_f7 = !((instr_i[31:25] == 7'b0000000) ||
                         (instr_i[31:25] == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
        else if (w_opcode == OPC_OP_IMM && w_is_shift)
            w_bad_f7 = !((instr_i[31:25] == 7'b0000000) ||
                         (instr_i[31:25] == 7'b0100000 && w_f3 == 3'b101));
    end
    assign illegal_o = !w_known || w_bad_f7;
`endif

    always_comb begin
        func_o    = FUNC_ZERO;
        op1_sel_o = OP1_ZERO;
        op2_sel_o = OP2_IMM;
        imm_o     = 32'd0;
        rd_we_o   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                func_o    = arith_func(w_f3, instr_i[30]);
                op1_sel_o = OP1_RS1;
                op2_sel_o = OP2_RS2;
                rd_we_o   = 1'b1;
            end
            OPC_OP_IMM: begin
                func_o    = arith_func(w_f3, (w_f3 == 3'b101) && instr_i[30]);
                op1_sel_o = OP1_RS1;
                imm_o     = w_is_shift ? w_shamt : w_imm_i;
                rd_we_o   = 1'b1;
            end
            OPC_LUI: begin
                func_o  = FUNC_ADD;
                imm_o   = w_imm_u;
                rd_we_o = 1'b1;
            end
            OPC_AUIPC: begin
                func_o    = FUNC_ADD;
                op1_sel_o = OP1_PC;
                imm_o     = w_imm_u;
                rd_we_o   = 1'b1;
            end
            OPC_LOAD: begin
                func_o    = FUNC_ADD;
                op1_sel_o = OP1_RS1;
                imm_o     = w_imm_i;
                rd_we_o   = 1'b1;
            end
            OPC_STORE: begin
                func_o    = FUNC_ADD;
                op1_sel_o = OP1_RS1;
                imm_o     = w_imm_s;
            end
            OPC_JAL, OPC_JALR: begin
                func_o    = FUNC_ADD;
                op1_sel_o = OP1_PC;
                op2_sel_o = OP2_FOUR;
                rd_we_o   = 1'b1;
            end
            OPC_BRANCH: begin
                case (w_f3[2:1])
                    2'b10:   func_o = FUNC_SLT;
                    2'b11:   func_o = FUNC_SLTU;
                    default: func_o = FUNC_SUB;
                endcase
                op1_sel_o = OP1_RS1;
                op2_sel_o = OP2_RS2;
            end
            default: ;
        endcase
`ifdef ALU_DEC_ILLEGAL_EN
        if (illegal_o) begin
            func_o    = FUNC_ZERO;
            op1_sel_o = OP1_ZERO;
            op2_sel_o = OP2_IMM;
            imm_o     = 32'd0;
            rd_we_o   = 1'b0;
        end
`endif
        if (instr_i[11:7] == 5'd0)
            rd_we_o = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decoder
// Purpose  : Registered execute-stage front end producing ALU func/op1/op2
//            behind a valid/ready handshake. Optional macro: ALU_DEC_ILLEGAL_EN.
// Revision : 1.0
// ============================================================================
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    alu_op_decoder_if.slave   bus
);

    logic [3:0]           func_d;
    op1_sel_e             op1_sel;
    op2_sel_e             op2_sel;
    logic [31:0]          imm;
    logic                 rd_we_d;
    logic [DataWidth-1:0] op1_d;
    logic [DataWidth-1:0] op2_d;

    logic                 valid_q;
    logic [3:0]           func_q;
    logic [DataWidth-1:0] op1_q;
    logic [DataWidth-1:0] op2_q;
    logic [4:0]           rd_q;
    logic                 rd_we_q;
    logic                 accept;

`ifdef ALU_DEC_ILLEGAL_EN
    logic illegal_d;
    logic illegal_q;
`endif

    alu_dec_comb u_dec (
        .instr_i   (bus.instr),
        .func_o    (func_d),
        .op1_sel_o (op1_sel),
        .op2_sel_o (op2_sel),
        .imm_o     (imm),
        .rd_we_o   (rd_we_d)
`ifdef ALU_DEC_ILLEGAL_EN
        ,
        .illegal_o (illegal_d)
`endif
    );

    always_comb begin
        op1_d = '0;
        case (op1_sel)
            OP1_RS1: op1_d = bus.rs1_data;
            OP1_PC:  op1_d = bus.pc;
            default: op1_d = '0;
        endcase
    end

    always_comb begin
        op2_d = '0;
        case (op2_sel)
            OP2_RS2:  op2_d = bus.rs2_data;
            OP2_IMM:  op2_d = DataWidth'(imm);
            OP2_FOUR: op2_d = DataWidth'(4);
            default:  op2_d = '0;
        endcase
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Flush only clears valid; stale payload is harmless once invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            func_q    <= FUNC_ZERO;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_q      <= 5'd0;
            rd_we_q   <= 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            func_q    <= func_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            rd_q      <= bus.instr[11:7];
            rd_we_q   <= rd_we_d;
`ifdef ALU_DEC_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.alu_func  = func_q;
    assign bus.alu_op1   = op1_q;
    assign bus.alu_op2   = op2_q;
    assign bus.rd        = rd_q;
    assign bus.rd_we     = rd_we_q;
`ifdef ALU_DEC_ILLEGAL_EN
    assign bus.illegal   = illegal_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_decoder
// Purpose  : Self-checking bench for alu_op_decoder (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_alu_op_decoder;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  func;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    vec_t sb[$];
    vec_t cur;

    alu_op_decoder_if #(.DataWidth(32)) bus ();

    alu_op_decoder #(.DataWidth(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [31:0] instr, pc, rs1, rs2, input logic [3:0] func,
                       input logic [31:0] op1, op2, input logic [4:0] rd,
                       input logic we, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.func = func; v.op1 = op1; v.op2 = op2; v.rd = rd; v.we = we; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v, input logic valid);
        cur          = v;
        bus.in_valid = valid;
        bus.instr    = v.instr;
        bus.pc       = v.pc;
        bus.rs1_data = v.rs1;
        bus.rs2_data = v.rs2;
    endtask

    task automatic cmp_out(input vec_t e);
        check("alu_func", {28'd0, bus.alu_func}, {28'd0, e.func});
        check("alu_op1", bus.alu_op1, e.op1);
        check("alu_op2", bus.alu_op2, e.op2);
        check("rd", {27'd0, bus.rd}, {27'd0, e.rd});
        check("rd_we", {31'd0, bus.rd_we}, {31'd0, e.we});
`ifdef ALU_DEC_ILLEGAL_EN
        check("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
`endif
    endtask

    // One cycle: inputs are set at the falling edge, checked 1 time unit later.
    task automatic step();
        logic exp_ready;
        logic drain;
        logic acc;
        #1;
        exp_ready = (sb.size() == 0) || bus.out_ready;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
        if (sb.size() != 0) cmp_out(sb[0]);
        drain = (sb.size() != 0) && bus.out_ready;
        acc   = bus.in_valid && exp_ready;
        if (rst) begin
            sb.delete();
        end else begin
            if (drain) void'(sb.pop_front());
            if (flush) sb.delete();
            else if (acc) sb.push_back(cur);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_all();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4 && sb.size() != 0; k++) step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".alu_func"}, {28'd0, bus.alu_func}, 32'd0);
        check({tag, ".alu_op1"}, bus.alu_op1, 32'd0);
        check({tag, ".alu_op2"}, bus.alu_op2, 32'd0);
        check({tag, ".rd"}, {27'd0, bus.rd}, 32'd0);
        check({tag, ".rd_we"}, {31'd0, bus.rd_we}, 32'd0);
`ifdef ALU_DEC_ILLEGAL_EN
        check({tag, ".illegal"}, {31'd0, bus.illegal}, 32'd0);
`endif
    endtask

    initial begin
        //   instr         pc          rs1         rs2         fn  op1         op2         rd  we ill
        add(32'h402081B3, 32'h0,      32'd10,     32'd3,      2,  32'd10,     32'd3,      3,  1, 0); // sub
        add(32'h4042D293, 32'h0,      32'h80000000, 32'h0,    9,  32'h80000000, 32'd4,    5,  1, 0); // srai
        add(32'hFFF00093, 32'h0,      32'h0,      32'h0,      1,  32'h0,      32'hFFFFFFFF, 1, 1, 0); // addi -1
        add(32'h0020E463, 32'h0,      32'd7,      32'd9,      10, 32'd7,      32'd9,      8,  0, 0); // bltu
        add(32'h0000057F, 32'h0,      32'd1,      32'd2,      0,  32'h0,      32'h0,      10, 0, 1); // opcode 7F
        add(32'h123453B7, 32'h0,      32'h55,     32'h0,      1,  32'h0,      32'h12345000, 7, 1, 0); // lui
        add(32'hFFFFF417, 32'h1000,   32'h0,      32'h0,      1,  32'h1000,   32'hFFFFF000, 8, 1, 0); // auipc
        add(32'hFFC12483, 32'h0,      32'h100,    32'h0,      1,  32'h100,    32'hFFFFFFFC, 9, 1, 0); // lw
        add(32'hFE532C23, 32'h0,      32'h200,    32'h77,     1,  32'h200,    32'hFFFFFFF8, 24, 0, 0); // sw
        add(32'h008000EF, 32'h2000,   32'h0,      32'h0,      1,  32'h2000,   32'd4,      1,  1, 0); // jal
        add(32'h00008067, 32'h3000,   32'h44,     32'h0,      1,  32'h3000,   32'd4,      0,  0, 0); // jalr x0
        add(32'h0020A233, 32'h0,      32'hFFFFFFFF, 32'd1,    4,  32'hFFFFFFFF, 32'd1,    4,  1, 0); // slt
        add(32'h0F05F513, 32'h0,      32'h1234,   32'h0,      7,  32'h1234,   32'hF0,     10, 1, 0); // andi
        add(32'h40008093, 32'h0,      32'd5,      32'h0,      1,  32'd5,      32'h400,    1,  1, 0); // addi, bit30 set
        add(32'h01F11113, 32'h0,      32'd3,      32'h0,      3,  32'd3,      32'd31,     2,  1, 0); // slli 31
        add(32'h00208063, 32'h0,      32'd4,      32'd4,      2,  32'd4,      32'd4,      0,  0, 0); // beq
`ifdef ALU_DEC_ILLEGAL_EN
        add(32'h02208133, 32'h0,      32'd6,      32'd7,      0,  32'h0,      32'h0,      2,  0, 1); // bad funct7
`else
        add(32'h02208133, 32'h0,      32'd6,      32'd7,      1,  32'd6,      32'd7,      2,  1, 0); // bad funct7
`endif

        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive(vecs[0], 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("reset");
        check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i], 1'b1);
            step();
        end
        drain_all();

        // Stall for three cycles with a pending input, then full-rate release.
        drive(vecs[0], 1'b1);
        step();
        bus.out_ready = 1'b0;
        drive(vecs[1], 1'b1);
        repeat (3) step();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(vecs[i], 1'b1);
            step();
        end
        drain_all();

        // Flush with a held entry and a concurrent input.
        bus.out_ready = 1'b0;
        drive(vecs[4], 1'b1);
        step();
        flush = 1'b1;
        drive(vecs[5], 1'b1);
        step();
        flush = 1'b0;
        check("flush.out_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        drive(vecs[6], 1'b1);
        step();
        drain_all();

        // Reset in the middle of a stall discards the held entry.
        bus.out_ready = 1'b0;
        drive(vecs[7], 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("mid_stall_reset");
        drain_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_decoder.md
# alu_op_decoder

Execute-stage front end that turns a decoded RISC-V RV32I instruction plus register-file operands into the 4-bit ALU function code and the two ALU operands. It sits between the register-read stage and the ALU, registering its outputs behind a valid/ready handshake. It is the producer side of the ALU `func`/`op1`/`op2` interface. It supports stall (back-pressure) and flush, so the pipeline can hold or squash the operation in flight.

## Interface
- `DataWidth`, default 32: operand and PC width. Only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: squash the stage contents; takes priority over all else except `rst`.
- `in_valid` in 1: instruction/operands on inputs are valid.
- `in_ready` out 1: stage can accept; `in_ready = !out_valid || out_ready`.
- `instr` in 32: raw instruction word.
- `pc` in DataWidth: PC of `instr`.
- `rs1_data`, `rs2_data` in DataWidth: register-file read data.
- `out_valid` out 1: registered ALU request valid.
- `out_ready` in 1: consumer accepts the request this cycle.
- `alu_func` out 4: ALU function code.
- `alu_op1`, `alu_op2` out DataWidth: ALU operands.
- `rd` out 5: destination register.
- `rd_we` out 1: write-back enable.
- `illegal` out 1: present only with `ALU_DEC_ILLEGAL_EN`.

## Operation
- Function codes: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, XOR=5, OR=6, AND=7, SRL=8, SRA=9, SLTU=10.
- OP (0110011): decoded from funct3 and funct7[5].
  - 000 gives ADD, or SUB when funct7[5]=1.
  - 001→SLL, 010→SLT, 011→SLTU, 100→XOR, 110→OR, 111→AND.
  - 101 gives SRL, or SRA when funct7[5]=1.
  - Operands: op1=rs1, op2=rs2.
- OP-IMM (0010011): same mapping, but funct7 is ignored except on shifts (no SUBI).
  - op1=rs1.
  - op2 = sign-extended I-imm.
  - Shifts use op2 = zero-extended instr[24:20].
- LUI: ADD, op1=0, op2={instr[31:12],12'b0}.
- AUIPC: ADD, op1=pc, op2 = the same U-immediate.
- LOAD: ADD, rs1 + I-imm.
- STORE: ADD, rs1 + S-imm, rd_we=0.
- JAL/JALR: ADD, op1=pc, op2=4 (link value).
- BRANCH: rd_we=0; the compare function depends on funct3.
  - BEQ/BNE → SUB.
  - BLT/BGE → SLT.
  - BLTU/BGEU → SLTU.
  - Operands: op1=rs1, op2=rs2.
- Any other opcode: alu_func=ZERO, op1=op2=0, rd_we=0.
- `rd` = instr[11:7]. `rd_we` is forced 0 when rd==0.
- All arithmetic is modulo 2^32; sign extension is taken from instr[31].

## Timing
- Latency is 1 cycle. An input accepted (in_valid && in_ready) at edge N is presented on the outputs after edge N.
- Outputs are fully registered. Nothing combinational from `instr` reaches the outputs.
- Hold rule: while out_valid && !out_ready, every output is held stable.
- Simultaneous accept and drain (out_valid && out_ready && in_valid): the new entry loads, and out_valid stays 1 (full throughput).
- Drain with no new input: out_valid drops to 0.
- `flush`: out_valid ← 0 at the next edge, even if in_valid && in_ready the same cycle. The input is dropped, and `in_ready` is still reported per the formula.
- Reset (`rst`, synchronous): out_valid=0, alu_func=0, alu_op1=0, alu_op2=0, rd=0, rd_we=0, illegal=0.
- Reset asserted mid-stall discards the held entry.

## Configuration
- `ALU_DEC_ILLEGAL_EN` defined:
  - the `illegal` port exists;
  - it is registered alongside the other outputs;
  - it is 1 for unknown opcodes and for bad OP/shift funct7 encodings.
  - An illegal entry still flows with out_valid=1, alu_func=ZERO, rd_we=0.
- `ALU_DEC_ILLEGAL_EN` undefined:
  - the port is absent;
  - illegal encodings are silently emitted as ZERO with rd_we=0;
  - bad funct7 on OP is decoded by funct7[5] only.

## Structure
- Shared package `alu_pkg` holds:
  - the function-code localparams (shared with the ALU);
  - the RV32I opcode constants;
  - an operand-select enum (RS1/PC/ZERO for op1; RS2/IMM/FOUR for op2).
- One combinational sub-module, `alu_dec_comb`: instr → func, operand selects, immediate, rd_we, illegal.
- The top level holds the operand muxes, the output register and the handshake.

## Test plan
- Reset behaviour: assert rst with in_valid=1 → all outputs 0 and out_valid=0 the next cycle.
- SUB: accept `sub x3,x1,x2` (0x402081B3) with rs1=10, rs2=3 and out_ready=1 → next cycle alu_func=2, op1=10, op2=3, rd=3, rd_we=1.
- Immediate forms:
  - `srai x5,x5,4` with rs1=0x80000000 → func=9, op2=4.
  - `addi x1,x0,-1` → func=1, op2=0xFFFFFFFF.
- Stall:
  - hold out_ready=0 for 3 cycles with in_valid=1 → outputs stable and in_ready=0;
  - release → back-to-back throughput, one request per cycle.
- Flush:
  - flush with a valid entry and a concurrent input → out_valid=0 next cycle;
  - the following accept proceeds normally.
- Branch and illegal:
  - `bltu` → func=10, rd_we=0.
  - Opcode 0x7F → func=0, rd_we=0, and illegal=1 when the macro is defined.
